d2l_link_arbiter: RTL
=====================

Name: d2l_link_arbiter

Overview:
- Shares one D2L serial link (start pulse, 71-bit {width, payload} command, one-cycle completion pulse, 64-bit result) among NREQ independent requesters.
- Arbitrates round-robin, screens commands for an illegal width, and launches the link with a one-cycle start pulse.
- Guards each transfer with a completion timeout and returns a tagged response (requester id, data, status) through a valid/ready handshake.
- Sits between the requester fabric and the D2L wrapper, in the same clk domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, WAIT-state cycles allowed before the transfer is declared failed (≥2).
- IDW, 2, requester id width; must satisfy 2**IDW ≥ NREQ.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_data  in  NREQ*71  per-requester command; slice k = req_data[71k+70:71k] = {width[6:0], payload[63:0]}.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  IDW  index of the served requester.
- resp_data  out  64  link result, or zero on error.
- resp_err  out  2  status: 00 ok, 01 bad width, 10 timeout.
- link_out_en  out  1  one-cycle start pulse to the link.
- link_data  out  71  command to the link, held stable from LAUNCH until the transfer ends.
- link_done  in  1  one-cycle completion pulse from the link.
- link_data_out  in  64  link result, valid in the link_done cycle.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. All state is cleared on reset.
- Reset values: state IDLE; req_ready 0; resp_valid 0; resp_id 0; resp_data 0; resp_err 00; link_out_en 0; link_data 0; busy 0; round-robin pointer = NREQ-1, so requester 0 has first priority; timer 0.
- Reset mid-transfer aborts silently: no response is produced, and a later link_done is ignored.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot grant over req_valid, searching from pointer+1 with wrap-around.
  - In the cycle a requester is granted, on that edge: latch its id and req_data slice, and set pointer = granted id.
  - If width == 0 or width > 64: go to RESP with resp_err 01 and resp_data 0. The link is never started.
  - Otherwise: go to LAUNCH and load link_data with the latched command.
- Requester side: a requester may hold req_valid high across cycles, and its data must stay stable until accepted. No accept happens in any state other than IDLE.
- LAUNCH: link_out_en = 1 for exactly this one cycle; timer cleared; then go to WAIT.
- WAIT:
  - The timer increments every cycle.
  - link_done = 1: capture link_data_out into resp_data, resp_err 00, go to RESP.
  - Otherwise, if the timer equals TIMEOUT-1: resp_data 0, resp_err 10, go to RESP.
  - If link_done and timeout coincide, link_done wins (ok).
- link_done is sampled only in WAIT; in IDLE, LAUNCH or RESP it is ignored, including a late done after a timeout.
- RESP:
  - resp_valid = 1, with resp_id, resp_data and resp_err held stable until resp_valid && resp_ready.
  - On that handshake: return to IDLE and clear resp_valid on the same edge.
  - A new grant can occur in the IDLE cycle that follows.
- Latency:
  - Accept edge T → link_out_en high in cycle T+1 → WAIT from T+2.
  - link_done in cycle D → resp_valid high from D+1.
  - Bad-width command → resp_valid high in cycle T+1.
- Fairness: after serving requester k, every other requester with valid held high is served before k is served again.
- Single outstanding transfer only; no buffering beyond the one latched command.

Test Plan:
- Single request, width 16, payload 64'h0000_0000_0000_ABCD, from req 2; link model returns 64'hABCD after 40 cycles → exactly one link_out_en pulse, link_data = {7'd16, payload}, resp_id 2, resp_data 64'hABCD, resp_err 00, resp_valid in the cycle after link_done.
- Requesters 0..3 all valid simultaneously from reset, link model with 10-cycle latency → grant order 0,1,2,3; then with 0 and 3 re-asserted after 3 is served → order 0,3.
- Command width 0, then width 65 → resp_err 01, resp_data 0, link_out_en never asserted, resp_valid one cycle after accept.
- TIMEOUT=32, link never asserts done → resp_err 10 exactly 32 cycles after WAIT entry; a late link_done injected in RESP is ignored and causes no second response.
- link_done arriving in the same cycle the timer reaches TIMEOUT-1 → resp_err 00, link data captured.
- resp_ready held low 5 cycles with req 1 valid → resp fields stable, req_ready stays 0, busy 1; rstn pulsed during WAIT → all outputs return to reset values, no response emitted, next grant goes to req 0.

Source files
------------

// File: rtl/d2l_link_arbiter.sv
// d2l_link_arbiter: round-robin front end for a shared D2L serial link.
// Grants one requester at a time, screens the command width, launches the
// link, guards the transfer with a timeout and returns a tagged response.
module d2l_link_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*71-1:0]   req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [63:0]          resp_data,
  output logic [1:0]           resp_err,
  output logic                 link_out_en,
  output logic [70:0]          link_data,
  input  logic                 link_done,
  input  logic [63:0]          link_data_out,
  output logic                 busy
);

  localparam int unsigned NR = NREQ;
  localparam int          TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [TW-1:0]  timer;

  logic [70:0]    cmd_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic           grant_any;
  logic [70:0]    sel_cmd;
  logic           bad_width;
  logic [IDW-1:0] idx;

  // Split the packed command bus into one entry per requester
  always_comb begin
    for (int unsigned k = 0; k < NR; k++) begin
      cmd_arr[k] = req_data[k*71 +: 71];
    end
  end

  // Round-robin search starting one past the last served requester
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = IDW'((32'(ptr) + i) % NR);
      if (!grant_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // Command of the winning requester and its width screen
  always_comb begin
    sel_cmd   = cmd_arr[grant_id];
    bad_width = (sel_cmd[70:64] == 7'd0) || (sel_cmd[70:64] > 7'd64);
  end

  // Accept is offered only while idle and out of reset
  assign req_ready = (state == IDLE && rstn) ? grant : '0;
  assign busy      = (state != IDLE);

  // Transfer sequencing with registered link and response outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ptr         <= IDW'(NREQ - 1);
      timer       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_data   <= '0;
      resp_err    <= 2'b00;
      link_out_en <= 1'b0;
      link_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr     <= grant_id;
            resp_id <= grant_id;
            if (bad_width) begin
              resp_data  <= '0;
              resp_err   <= 2'b01;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              link_data   <= sel_cmd;
              link_out_en <= 1'b1;
              timer       <= '0;
              state       <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          link_out_en <= 1'b0;
          timer       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (link_done) begin
            resp_data  <= link_data_out;
            resp_err   <= 2'b00;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            resp_data  <= '0;
            resp_err   <= 2'b10;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
